card_match_engine: RTL and testbench
====================================

CARD_MATCH_ENGINE -- requirements
Module: card_match_engine

Interface
REQ-001 Parameter NUM_CARDS, 36, board size; SHALL be even and at least 2.
REQ-002 Parameter VAL_W, 5, card face value width.
REQ-003 Parameter ADDR_W, $clog2(NUM_CARDS), card address width.
REQ-004 Parameter RD_LAT, 1, board memory read latency in cycles.
REQ-005 Parameter HOLD_CYCLES, 25000000, mismatch display time in cycles, at least 1.
REQ-006 Parameter MOVE_W, 8, move counter width.
REQ-007 clock  in  1  sole clock, rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 enable  in  1  game is in card-select state.
REQ-010 select  in  1  select button, level; block edge-detects internally.
REQ-011 new_game  in  1  synchronous clear of game progress.
REQ-012 cursor  in  ADDR_W  card under cursor.
REQ-013 rd_addr  out  ADDR_W  board memory read address, registered.
REQ-014 rd_data  in  VAL_W  board memory data, valid RD_LAT cycles after rd_addr is sampled.
REQ-015 card1_addr, card2_addr  out  ADDR_W each  selected card addresses.
REQ-016 card1_val, card2_val  out  VAL_W each  selected card values.
REQ-017 card1_valid, card2_valid  out  1 each  card face-up flags.
REQ-018 matched_mask  out  NUM_CARDS  bit i set when card i is paired.
REQ-019 pairs_found  out  ADDR_W  number of pairs matched.
REQ-020 moves  out  MOVE_W  completed comparisons.
REQ-021 match_pulse, mismatch_pulse  out  1 each  one-cycle result strobes.
REQ-022 busy  out  1  high in READ1, READ2, COMPARE and HOLD states.
REQ-023 game_over  out  1  all pairs found.

Function
REQ-024 The FSM SHALL have states WAIT1, READ1, WAIT2, READ2, COMPARE, HOLD and DONE.
REQ-025 A select press SHALL be a 0-to-1 transition of select sampled at consecutive edges.
REQ-026 A press SHALL be accepted only in WAIT1 or WAIT2 with enable=1, cursor<NUM_CARDS and matched_mask[cursor]=0; in WAIT2 it also requires cursor!=card1_addr.
REQ-027 An accepted press in WAIT1 SHALL load card1_addr and rd_addr with cursor and enter READ1; in WAIT2 it SHALL load card2_addr and rd_addr and enter READ2.
REQ-028 READ1 and READ2 SHALL last RD_LAT+1 cycles, then capture rd_data into card1_val/card2_val, set card1_valid/card2_valid, and go to WAIT2 or COMPARE respectively.
REQ-029 COMPARE SHALL last one cycle and increment moves, saturating at all ones.
REQ-030 On equal values, COMPARE SHALL set both mask bits, increment pairs_found, pulse match_pulse, clear both valids, and go to DONE when pairs_found becomes NUM_CARDS/2, otherwise to WAIT1.
REQ-031 On unequal values, COMPARE SHALL pulse mismatch_pulse and enter HOLD with both valids held high.
REQ-032 HOLD SHALL last exactly HOLD_CYCLES cycles, ignore presses, then clear both valids and go to WAIT1.
REQ-033 DONE SHALL assert game_over and ignore presses until new_game.
REQ-034 Deasserting enable in READ1, WAIT2 or READ2 SHALL clear both valids and return to WAIT1 without changing moves or pairs; HOLD and COMPARE complete normally.
REQ-035 new_game=1 SHALL, in any state, take priority over all other events: clear mask, pairs_found, moves, valids, strobes and game_over, and enter WAIT1 on the next edge.
REQ-036 A press arriving in any non-accepting state SHALL be discarded, not queued.

Reset
REQ-037 reset_n=0 SHALL asynchronously force state WAIT1, all outputs and counters to 0, and the select edge-detector history to 1, so a held button does not register as a press.
REQ-038 Deasserting reset_n SHALL take effect on the next rising clock edge.

Verification
REQ-039 With NUM_CARDS=4, HOLD_CYCLES=3, a board of {7,7,2,2}, selecting 0 then 1 -> match_pulse for 1 cycle, matched_mask=0011, pairs_found=1, moves=1.
REQ-040 Same board, selecting 0 then 2 -> mismatch_pulse, valids high for exactly 3 cycles, then cleared; moves=1, mask=0000.
REQ-041 Selecting 0 twice, a matched card, or cursor=5 -> no state change and no read.
REQ-042 Clearing all pairs -> game_over=1 and presses ignored; new_game -> game_over=0, mask=0, moves=0.
REQ-043 With MOVE_W=2, 5 mismatches -> moves=3, saturated.
REQ-044 reset_n pulsed low in HOLD, and deasserted with select held high -> outputs immediately 0, state WAIT1, and no press until select is released and pressed again.

Source files
------------

// File: rtl/card_match_engine.sv
// Memory-style card matching engine: takes two selections, reads their faces
// from an external board memory, compares them and tracks game progress.
module card_match_engine #(
  parameter int unsigned NUM_CARDS   = 36,
  parameter int unsigned VAL_W       = 5,
  parameter int unsigned ADDR_W      = $clog2(NUM_CARDS),
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned MOVE_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 select,
  input  logic                 new_game,
  input  logic [ADDR_W-1:0]    cursor,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [VAL_W-1:0]     rd_data,
  output logic [ADDR_W-1:0]    card1_addr,
  output logic [ADDR_W-1:0]    card2_addr,
  output logic [VAL_W-1:0]     card1_val,
  output logic [VAL_W-1:0]     card2_val,
  output logic                 card1_valid,
  output logic                 card2_valid,
  output logic [NUM_CARDS-1:0] matched_mask,
  output logic [ADDR_W-1:0]    pairs_found,
  output logic [MOVE_W-1:0]    moves,
  output logic                 match_pulse,
  output logic                 mismatch_pulse,
  output logic                 busy,
  output logic                 game_over
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > RD_LAT) ? HOLD_CYCLES : RD_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PAD_N   = 1 << ADDR_W;
  localparam int unsigned HALF    = NUM_CARDS / 2;

  typedef enum logic [2:0] {
    S_WAIT1   = 3'd0,
    S_READ1   = 3'd1,
    S_WAIT2   = 3'd2,
    S_READ2   = 3'd3,
    S_COMPARE = 3'd4,
    S_HOLD    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]    card1_addr_q, card1_addr_d;
  logic [ADDR_W-1:0]    card2_addr_q, card2_addr_d;
  logic [VAL_W-1:0]     card1_val_q, card1_val_d;
  logic [VAL_W-1:0]     card2_val_q, card2_val_d;
  logic                 card1_valid_q, card1_valid_d;
  logic                 card2_valid_q, card2_valid_d;
  logic [NUM_CARDS-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]    pairs_q, pairs_d;
  logic [MOVE_W-1:0]    moves_q, moves_d;
  logic                 match_q, match_d;
  logic                 mismatch_q, mismatch_d;
  logic                 busy_q, busy_d;
  logic                 game_over_q, game_over_d;

  logic                 press;
  logic                 cur_free;
  logic [PAD_N-1:0]     mask_pad;

  // Pad the mask to the full address space so any cursor value indexes safely
  assign mask_pad = PAD_N'(mask_q);
  assign press    = select & ~sel_q;
  assign cur_free = (32'(cursor) < NUM_CARDS) && !mask_pad[cursor];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = select;
    rd_addr_d     = rd_addr_q;
    card1_addr_d  = card1_addr_q;
    card2_addr_d  = card2_addr_q;
    card1_val_d   = card1_val_q;
    card2_val_d   = card2_val_q;
    card1_valid_d = card1_valid_q;
    card2_valid_d = card2_valid_q;
    mask_d        = mask_q;
    pairs_d       = pairs_q;
    moves_d       = moves_q;
    match_d       = 1'b0;
    mismatch_d    = 1'b0;

    if (new_game) begin
      state_d       = S_WAIT1;
      cnt_d         = '0;
      card1_valid_d = 1'b0;
      card2_valid_d = 1'b0;
      mask_d        = '0;
      pairs_d       = '0;
      moves_d       = '0;
    end else begin
      unique case (state_q)
        S_WAIT1: begin
          if (press && enable && cur_free) begin
            card1_addr_d = cursor;
            rd_addr_d    = cursor;
            cnt_d        = '0;
            state_d      = S_READ1;
          end
        end
        S_READ1: begin
          if (!enable) begin
            card1_valid_d = 1'b0;
            card2_valid_d = 1'b0;
            state_d       = S_WAIT1;
          end else if (cnt_q == CNT_W'(RD_LAT)) begin
            card1_val_d   = rd_data;
            card1_valid_d = 1'b1;
            state_d       = S_WAIT2;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT2: begin
          if (!enable) begin
            card1_valid_d = 1'b0;
            card2_valid_d = 1'b0;
            state_d       = S_WAIT1;
          end else if (press && cur_free && (cursor != card1_addr_q)) begin
            card2_addr_d = cursor;
            rd_addr_d    = cursor;
            cnt_d        = '0;
            state_d      = S_READ2;
          end
        end
        S_READ2: begin
          if (!enable) begin
            card1_valid_d = 1'b0;
            card2_valid_d = 1'b0;
            state_d       = S_WAIT1;
          end else if (cnt_q == CNT_W'(RD_LAT)) begin
            card2_val_d   = rd_data;
            card2_valid_d = 1'b1;
            state_d       = S_COMPARE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_COMPARE: begin
          if (moves_q != '1) moves_d = moves_q + MOVE_W'(1);
          if (card1_val_q == card2_val_q) begin
            mask_d        = mask_q | (NUM_CARDS'(1) << card1_addr_q)
                                   | (NUM_CARDS'(1) << card2_addr_q);
            pairs_d       = pairs_q + ADDR_W'(1);
            match_d       = 1'b1;
            card1_valid_d = 1'b0;
            card2_valid_d = 1'b0;
            state_d       = (pairs_d == ADDR_W'(HALF)) ? S_DONE : S_WAIT1;
          end else begin
            mismatch_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            card1_valid_d = 1'b0;
            card2_valid_d = 1'b0;
            state_d       = S_WAIT1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_WAIT1;
        end
      endcase
    end

    busy_d      = state_d inside {S_READ1, S_READ2, S_COMPARE, S_HOLD};
    game_over_d = (state_d == S_DONE);
  end

  // Select history resets high so a button held through reset is not a press
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_WAIT1;
      cnt_q         <= '0;
      sel_q         <= 1'b1;
      rd_addr_q     <= '0;
      card1_addr_q  <= '0;
      card2_addr_q  <= '0;
      card1_val_q   <= '0;
      card2_val_q   <= '0;
      card1_valid_q <= 1'b0;
      card2_valid_q <= 1'b0;
      mask_q        <= '0;
      pairs_q       <= '0;
      moves_q       <= '0;
      match_q       <= 1'b0;
      mismatch_q    <= 1'b0;
      busy_q        <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      rd_addr_q     <= rd_addr_d;
      card1_addr_q  <= card1_addr_d;
      card2_addr_q  <= card2_addr_d;
      card1_val_q   <= card1_val_d;
      card2_val_q   <= card2_val_d;
      card1_valid_q <= card1_valid_d;
      card2_valid_q <= card2_valid_d;
      mask_q        <= mask_d;
      pairs_q       <= pairs_d;
      moves_q       <= moves_d;
      match_q       <= match_d;
      mismatch_q    <= mismatch_d;
      busy_q        <= busy_d;
      game_over_q   <= game_over_d;
    end
  end

  assign rd_addr        = rd_addr_q;
  assign card1_addr     = card1_addr_q;
  assign card2_addr     = card2_addr_q;
  assign card1_val      = card1_val_q;
  assign card2_val      = card2_val_q;
  assign card1_valid    = card1_valid_q;
  assign card2_valid    = card2_valid_q;
  assign matched_mask   = mask_q;
  assign pairs_found    = pairs_q;
  assign moves          = moves_q;
  assign match_pulse    = match_q;
  assign mismatch_pulse = mismatch_q;
  assign busy           = busy_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_card_match_engine.sv
// Bench for card_match_engine: directed scenarios plus randomized presses
// checked against a game-level reference model.
module tb_card_match_engine;

  localparam int unsigned N    = 6;
  localparam int unsigned VW   = 5;
  localparam int unsigned AW   = 3;
  localparam int unsigned HOLD = 3;
  localparam int unsigned MW   = 2;
  localparam int          MMAX = (1 << MW) - 1;

  logic          clock;
  logic          reset_n;
  logic          enable;
  logic          select;
  logic          new_game;
  logic [AW-1:0] cursor;
  logic [AW-1:0] rd_addr;
  logic [VW-1:0] rd_data;
  logic [AW-1:0] card1_addr, card2_addr;
  logic [VW-1:0] card1_val, card2_val;
  logic          card1_valid, card2_valid;
  logic [N-1:0]  matched_mask;
  logic [AW-1:0] pairs_found;
  logic [MW-1:0] moves;
  logic          match_pulse, mismatch_pulse;
  logic          busy, game_over;

  int checks = 0;
  int errors = 0;

  card_match_engine #(
    .NUM_CARDS(N), .VAL_W(VW), .RD_LAT(1), .HOLD_CYCLES(HOLD), .MOVE_W(MW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .select(select),
    .new_game(new_game), .cursor(cursor), .rd_addr(rd_addr), .rd_data(rd_data),
    .card1_addr(card1_addr), .card2_addr(card2_addr),
    .card1_val(card1_val), .card2_val(card2_val),
    .card1_valid(card1_valid), .card2_valid(card2_valid),
    .matched_mask(matched_mask), .pairs_found(pairs_found), .moves(moves),
    .match_pulse(match_pulse), .mismatch_pulse(mismatch_pulse),
    .busy(busy), .game_over(game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Board memory with one cycle of read latency
  logic [VW-1:0] board [8];
  always @(posedge clock) rd_data <= board[rd_addr];

  // Event counters sampled on the falling edge
  int match_cnt = 0;
  int mis_cnt   = 0;
  int rise_cnt  = 0;
  logic busy_prev = 1'b0;
  always @(negedge clock) begin
    if (match_pulse) match_cnt++;
    if (mismatch_pulse) mis_cnt++;
    if (busy && !busy_prev) rise_cnt++;
    busy_prev = busy;
  end

  // Game-level model: phase 0 = choosing first card, 1 = second, 2 = game over
  logic [N-1:0] m_mask;
  int m_pairs, m_moves, m_phase, m_c1;

  task automatic model_clear();
    m_mask = '0; m_pairs = 0; m_moves = 0; m_phase = 0; m_c1 = 0;
  endtask

  task automatic model_press(input int c, output int e_read, output int e_match, output int e_mis);
    e_read = 0; e_match = 0; e_mis = 0;
    if (m_phase == 0) begin
      if (c < N && !m_mask[c]) begin
        m_c1 = c; m_phase = 1; e_read = 1;
      end
    end else if (m_phase == 1) begin
      if (c < N && !m_mask[c] && c != m_c1) begin
        e_read = 1;
        m_moves = (m_moves >= MMAX) ? MMAX : m_moves + 1;
        if (board[m_c1] == board[c]) begin
          m_mask[m_c1] = 1'b1; m_mask[c] = 1'b1; m_pairs++;
          e_match = 1;
          m_phase = (m_pairs == N / 2) ? 2 : 0;
        end else begin
          e_mis = 1; m_phase = 0;
        end
      end
    end
  endtask

  task automatic press_card(input int c, output int e_read, output int e_match, output int e_mis);
    model_press(c, e_read, e_match, e_mis);
    @(negedge clock); cursor = AW'(c); select = 1'b1;
    @(negedge clock); select = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic do_new_game();
    @(negedge clock); new_game = 1'b1;
    @(negedge clock); new_game = 1'b0;
    @(negedge clock);
    model_clear();
  endtask

  task automatic set_fixed_board();
    board[0] = 5'd7; board[1] = 5'd7; board[2] = 5'd2; board[3] = 5'd2;
    board[4] = 5'd4; board[5] = 5'd4; board[6] = 5'd0; board[7] = 5'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; select = 1'b0; new_game = 1'b0; cursor = '0;
    #12;
    checks++;
    if ({rd_addr, matched_mask, pairs_found, moves} !== '0) begin
      errors++;
      $display("FAIL reset_counters got addr=%0d mask=%b pairs=%0d moves=%0d want all 0",
               rd_addr, matched_mask, pairs_found, moves);
    end
    checks++;
    if ({card1_valid, card2_valid, match_pulse, mismatch_pulse, busy, game_over} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {card1_valid, card2_valid, match_pulse, mismatch_pulse, busy, game_over});
    end
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);
    model_clear();
  endtask

  task automatic test_match();
    int r0, m0, e_r, e_m, e_x;
    set_fixed_board();
    do_new_game();
    r0 = rise_cnt; m0 = match_cnt;
    press_card(0, e_r, e_m, e_x);
    checks++;
    if (card1_valid !== 1'b1 || card1_addr !== 3'd0 || card1_val !== 5'd7) begin
      errors++;
      $display("FAIL first_card got valid=%b addr=%0d val=%0d want 1/0/7", card1_valid, card1_addr, card1_val);
    end
    press_card(1, e_r, e_m, e_x);
    checks++;
    if (match_cnt - m0 !== 1) begin
      errors++; $display("FAIL match_pulse_cycles got %0d want 1", match_cnt - m0);
    end
    checks++;
    if (matched_mask !== 6'b000011 || pairs_found !== 3'd1 || moves !== 2'd1) begin
      errors++;
      $display("FAIL match_state got mask=%b pairs=%0d moves=%0d want 000011/1/1", matched_mask, pairs_found, moves);
    end
    checks++;
    if (card1_valid !== 1'b0 || card2_valid !== 1'b0 || rise_cnt - r0 !== 2) begin
      errors++;
      $display("FAIL match_clear got v1=%b v2=%b reads=%0d want 0/0/2", card1_valid, card2_valid, rise_cnt - r0);
    end
  endtask

  task automatic test_reject();
    int r0, e_r, e_m, e_x;
    set_fixed_board();
    do_new_game();
    press_card(0, e_r, e_m, e_x);
    r0 = rise_cnt;
    press_card(0, e_r, e_m, e_x);
    press_card(7, e_r, e_m, e_x);
    press_card(6, e_r, e_m, e_x);
    checks++;
    if (rise_cnt - r0 !== 0 || rd_addr !== 3'd0 || card1_valid !== 1'b1 || card2_valid !== 1'b0) begin
      errors++;
      $display("FAIL reject_same_or_range got reads=%0d addr=%0d v1=%b v2=%b want 0/0/1/0",
               rise_cnt - r0, rd_addr, card1_valid, card2_valid);
    end
    press_card(1, e_r, e_m, e_x);
    r0 = rise_cnt;
    press_card(1, e_r, e_m, e_x);
    checks++;
    if (rise_cnt - r0 !== 0 || card1_valid !== 1'b0 || rd_addr !== 3'd1) begin
      errors++;
      $display("FAIL reject_matched got reads=%0d v1=%b addr=%0d want 0/0/1", rise_cnt - r0, card1_valid, rd_addr);
    end
  endtask

  task automatic test_mismatch_hold();
    int r0, x0, v, e_r, e_m, e_x;
    bit found;
    set_fixed_board();
    do_new_game();
    press_card(0, e_r, e_m, e_x);
    model_press(2, e_r, e_m, e_x);
    r0 = rise_cnt; x0 = mis_cnt;
    @(negedge clock); cursor = 3'd2; select = 1'b1;
    @(negedge clock); select = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mismatch_pulse) found = 1'b1;
      else @(negedge clock);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL mismatch_timeout got no mismatch_pulse want one within 20 cycles");
    end
    v = 0;
    while (found && card1_valid && card2_valid && v < 20) begin
      v++;
      if (v == 1) begin cursor = 3'd4; select = 1'b1; end
      if (v == 2) select = 1'b0;
      @(negedge clock);
    end
    select = 1'b0;
    checks++;
    if (v !== HOLD) begin
      errors++; $display("FAIL hold_valid_cycles got %0d want %0d", v, HOLD);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (mis_cnt - x0 !== 1 || rise_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL hold_ignores_press got pulses=%0d reads=%0d want 1/1", mis_cnt - x0, rise_cnt - r0);
    end
    checks++;
    if (moves !== 2'd1 || matched_mask !== 6'b0 || card1_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_state got moves=%0d mask=%b v1=%b busy=%b want 1/000000/0/0",
               moves, matched_mask, card1_valid, busy);
    end
  endtask

  task automatic test_enable_abort();
    int e_r, e_m, e_x;
    set_fixed_board();
    do_new_game();
    press_card(2, e_r, e_m, e_x);
    @(negedge clock); enable = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (card1_valid !== 1'b0 || moves !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait2 got v1=%b moves=%0d busy=%b want 0/0/0", card1_valid, moves, busy);
    end
    enable = 1'b1; m_phase = 0;
    @(negedge clock); cursor = 3'd3; select = 1'b1;
    @(negedge clock); select = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (card1_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_read1 got v1=%b busy=%b want 0/0", card1_valid, busy);
    end
    enable = 1'b1;
    press_card(3, e_r, e_m, e_x);
    press_card(2, e_r, e_m, e_x);
    checks++;
    if (pairs_found !== 3'd1 || moves !== 2'd1 || matched_mask !== 6'b001100) begin
      errors++;
      $display("FAIL after_abort got pairs=%0d moves=%0d mask=%b want 1/1/001100", pairs_found, moves, matched_mask);
    end
  endtask

  task automatic test_game_over();
    int r0, e_r, e_m, e_x;
    set_fixed_board();
    do_new_game();
    for (int c = 0; c < N; c++) press_card(c, e_r, e_m, e_x);
    checks++;
    if (game_over !== 1'b1 || pairs_found !== 3'd3 || matched_mask !== 6'b111111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL game_over got go=%b pairs=%0d mask=%b busy=%b want 1/3/111111/0",
               game_over, pairs_found, matched_mask, busy);
    end
    r0 = rise_cnt;
    press_card(0, e_r, e_m, e_x);
    press_card(7, e_r, e_m, e_x);
    checks++;
    if (rise_cnt - r0 !== 0 || game_over !== 1'b1) begin
      errors++; $display("FAIL done_ignores got reads=%0d go=%b want 0/1", rise_cnt - r0, game_over);
    end
    do_new_game();
    checks++;
    if (game_over !== 1'b0 || matched_mask !== 6'b0 || moves !== 2'd0 || pairs_found !== 3'd0) begin
      errors++;
      $display("FAIL new_game_clear got go=%b mask=%b moves=%0d pairs=%0d want 0/0/0/0",
               game_over, matched_mask, moves, pairs_found);
    end
  endtask

  task automatic test_saturation();
    int x0, e_r, e_m, e_x;
    set_fixed_board();
    do_new_game();
    x0 = mis_cnt;
    for (int k = 0; k < 5; k++) begin
      press_card(0, e_r, e_m, e_x);
      press_card(2, e_r, e_m, e_x);
    end
    checks++;
    if (moves !== 2'd3 || mis_cnt - x0 !== 5) begin
      errors++; $display("FAIL moves_saturate got moves=%0d mism=%0d want 3/5", moves, mis_cnt - x0);
    end
  endtask

  task automatic test_reset_in_hold();
    int r0, e_r, e_m, e_x;
    bit found;
    set_fixed_board();
    do_new_game();
    press_card(0, e_r, e_m, e_x);
    @(negedge clock); cursor = 3'd2; select = 1'b1;
    @(negedge clock); select = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mismatch_pulse) found = 1'b1;
      else @(negedge clock);
    end
    @(negedge clock);
    select = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (!found || {card1_valid, card2_valid, busy, mismatch_pulse} !== 4'b0 || moves !== 2'd0 || rd_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_hold got found=%b flags=%b moves=%0d addr=%0d want 1/0000/0/0",
               found, {card1_valid, card2_valid, busy, mismatch_pulse}, moves, rd_addr);
    end
    @(negedge clock); reset_n = 1'b1;
    model_clear();
    r0 = rise_cnt;
    repeat (4) @(negedge clock);
    checks++;
    if (rise_cnt - r0 !== 0 || card1_valid !== 1'b0) begin
      errors++; $display("FAIL held_select got reads=%0d v1=%b want 0/0", rise_cnt - r0, card1_valid);
    end
    select = 1'b0;
    repeat (2) @(negedge clock);
    press_card(0, e_r, e_m, e_x);
    checks++;
    if (card1_valid !== 1'b1 || rise_cnt - r0 !== 1) begin
      errors++; $display("FAIL press_after_release got v1=%b reads=%0d want 1/1", card1_valid, rise_cnt - r0);
    end
  endtask

  task automatic test_random();
    int r0, m0, x0, e_r, e_m, e_x, c;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 8; i++) board[i] = VW'($urandom_range(0, 3));
      do_new_game();
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 24) == 0) do_new_game();
        c = int'($urandom_range(0, 7));
        r0 = rise_cnt; m0 = match_cnt; x0 = mis_cnt;
        press_card(c, e_r, e_m, e_x);
        checks++;
        if (rise_cnt - r0 !== e_r || match_cnt - m0 !== e_m || mis_cnt - x0 !== e_x) begin
          errors++;
          $display("FAIL rand_events card=%0d got reads=%0d match=%0d mism=%0d want %0d/%0d/%0d",
                   c, rise_cnt - r0, match_cnt - m0, mis_cnt - x0, e_r, e_m, e_x);
        end
        checks++;
        if (matched_mask !== m_mask || int'(pairs_found) !== m_pairs || int'(moves) !== m_moves) begin
          errors++;
          $display("FAIL rand_progress card=%0d got mask=%b pairs=%0d moves=%0d want %b/%0d/%0d",
                   c, matched_mask, pairs_found, moves, m_mask, m_pairs, m_moves);
        end
        checks++;
        if (card1_valid !== (m_phase == 1) || game_over !== (m_phase == 2) || busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_phase card=%0d got v1=%b go=%b busy=%b want phase %0d idle",
                   c, card1_valid, game_over, busy, m_phase);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_reject();
    test_mismatch_hold();
    test_enable_abort();
    test_game_over();
    test_saturation();
    test_reset_in_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
